// File: rtl/door_pkg.sv
// Shared definitions for the timed automatic-door controller: state codes and widths.
package door_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CLOSED    = 3'd0,
        ST_OPENING   = 3'd1,
        ST_OPEN_HOLD = 3'd2,
        ST_CLOSING   = 3'd3,
        ST_FAULT     = 3'd4
    } door_state_e;

endpackage

// File: rtl/door_ctrl_timed_if.sv
// Door controller pin bundle: raw field inputs and enable toward the block, motor/status back out.
interface door_ctrl_timed_if;
    import door_pkg::*;

    logic               ena;
    logic               sensor;
    logic               obstruct;
    logic               lim_open;
    logic               lim_closed;
    logic               lock;
    logic               fault_clr;
    logic               motor_open;
    logic               motor_close;
    logic               fault;
    logic [STATE_W-1:0] state;

    modport master (
        output ena, sensor, obstruct, lim_open, lim_closed, lock, fault_clr,
        input  motor_open, motor_close, fault, state
    );

    modport slave (
        input  ena, sensor, obstruct, lim_open, lim_closed, lock, fault_clr,
        output motor_open, motor_close, fault, state
    );

endinterface

// File: rtl/door_tick_timer.sv
// Prescaler producing a one-cycle tick every PRESCALE enabled cycles, plus a saturating tick counter.
module door_tick_timer #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count
);

    localparam logic [CNT_W-1:0] ZERO       = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] count_r;

    assign tick       = en & (presc_r == PRESC_LAST);
    assign tick_count = count_r;

    // Prescaler and tick counter; clear wins, otherwise advance only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= ZERO;
            count_r <= ZERO;
        end else if (clr) begin
            presc_r <= ZERO;
            count_r <= ZERO;
        end else if (en) begin
            presc_r <= tick ? ZERO : (presc_r + ONE);
            if (tick && (count_r != CNT_MAX)) begin
                count_r <= count_r + ONE;
            end
        end
    end

endmodule

// File: rtl/door_ctrl_timed.sv
// Automatic door controller: synchronised field inputs, timed hold-open, travel timeout and fault latch.
module door_ctrl_timed
    import door_pkg::*;
#(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned TRAVEL_TICKS = 100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    door_ctrl_timed_if.slave dif
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_N   = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] TRAVEL_N = CNT_W'(TRAVEL_TICKS);

    logic [5:0]       in_s;
    logic [5:0]       sync1_r;
    logic [5:0]       sync2_r;
    logic [1:0]       warm_r;
    logic             sensor_s;
    logic             obstruct_s;
    logic             lim_open_s;
    logic             lim_closed_s;
    logic             lock_s;
    logic             fault_clr_s;
    logic             conflict_s;
    logic             step_s;
    logic             reload_s;
    logic             timer_clr_s;
    logic             tick_s;
    logic [CNT_W-1:0] tick_count_s;
    logic             hold_done_s;
    logic             travel_done_s;
    door_state_e      state_r;
    door_state_e      next_s;

    // True on the edge where the counter reaches n ticks, so expiry lands exactly n*PRESCALE cycles after clear
    function automatic logic timer_reached(input logic [CNT_W-1:0] cnt,
                                           input logic             tk,
                                           input logic [CNT_W-1:0] n);
        return (cnt == n) || (tk && (cnt == (n - ONE)));
    endfunction

    assign in_s = {dif.fault_clr, dif.lock, dif.lim_closed, dif.lim_open, dif.obstruct, dif.sensor};

    // Two-flop synchronisers plus a warm-up flag; these run regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 6'b000000;
            sync2_r <= 6'b000000;
            warm_r  <= 2'b00;
        end else begin
            sync1_r <= in_s;
            sync2_r <= sync1_r;
            warm_r  <= {warm_r[0], 1'b1};
        end
    end

    assign sensor_s     = sync2_r[0];
    assign obstruct_s   = sync2_r[1];
    assign lim_open_s   = sync2_r[2];
    assign lim_closed_s = sync2_r[3];
    assign lock_s       = sync2_r[4];
    assign fault_clr_s  = sync2_r[5];
    assign conflict_s   = lim_open_s & lim_closed_s;

    // The FSM waits until the synchronisers carry real samples, so cleared flops never fake an open door
    assign step_s = dif.ena & warm_r[1];

    door_tick_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (step_s),
        .clr        (timer_clr_s),
        .tick       (tick_s),
        .tick_count (tick_count_s)
    );

    assign hold_done_s   = timer_reached(tick_count_s, tick_s, HOLD_N);
    assign travel_done_s = timer_reached(tick_count_s, tick_s, TRAVEL_N);

    // Next-state decode; limit conflict overrides everything outside FAULT
    always_comb begin
        next_s   = state_r;
        reload_s = 1'b0;
        if (!step_s) begin
            next_s = state_r;
        end else if (conflict_s && (state_r != ST_FAULT)) begin
            next_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_CLOSED: begin
                    if (sensor_s && !lock_s) begin
                        next_s = ST_OPENING;
                    end else if (!lim_closed_s && !sensor_s) begin
                        next_s = ST_CLOSING;
                    end else begin
                        next_s = ST_CLOSED;
                    end
                end
                ST_OPENING: begin
                    if (lim_open_s) begin
                        next_s = ST_OPEN_HOLD;
                    end else if (travel_done_s) begin
                        next_s = ST_FAULT;
                    end else begin
                        next_s = ST_OPENING;
                    end
                end
                ST_OPEN_HOLD: begin
                    if (sensor_s || obstruct_s) begin
                        reload_s = 1'b1;
                    end else if (hold_done_s) begin
                        next_s = ST_CLOSING;
                    end else begin
                        next_s = ST_OPEN_HOLD;
                    end
                end
                ST_CLOSING: begin
                    if (sensor_s || obstruct_s) begin
                        next_s = ST_OPENING;
                    end else if (lim_closed_s) begin
                        next_s = ST_CLOSED;
                    end else if (travel_done_s) begin
                        next_s = ST_FAULT;
                    end else begin
                        next_s = ST_CLOSING;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr_s && !conflict_s) begin
                        next_s = lim_closed_s ? ST_CLOSED : ST_CLOSING;
                    end else begin
                        next_s = ST_FAULT;
                    end
                end
                default: begin
                    next_s = ST_FAULT;
                end
            endcase
        end
    end

    assign timer_clr_s = (next_s != state_r) | reload_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLOSED;
        end else begin
            state_r <= next_s;
        end
    end

    // Moore decode from the registered state; ena gates only the motor drives
    assign dif.motor_open  = dif.ena & (state_r == ST_OPENING);
    assign dif.motor_close = dif.ena & (state_r == ST_CLOSING);
    assign dif.fault       = (state_r == ST_FAULT);
    assign dif.state       = state_r;

endmodule

// File: tb/tb_door_ctrl_timed.sv
// Self-checking bench: directed scenarios plus random field inputs against a cycle-counting door model.
module tb_door_ctrl_timed;

    localparam int P  = 4;
    localparam int HT = 3;
    localparam int TT = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // reference model: state code, enabled cycles since entry/reload, warm-up edges, 2-edge input delay line
    int       m_st;
    int       m_el;
    int       m_w;
    bit [5:0] m_d1;
    bit [5:0] m_d2;

    door_ctrl_timed_if dif ();

    door_ctrl_timed #(
        .PRESCALE     (P),
        .HOLD_TICKS   (HT),
        .TRAVEL_TICKS (TT),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("state", int'(dif.state), m_st);
        check_val("motor_open", int'(dif.motor_open), int'(m_st == 1 && dif.ena));
        check_val("motor_close", int'(dif.motor_close), int'(m_st == 3 && dif.ena));
        check_val("fault", int'(dif.fault), int'(m_st == 4));
        check_val("interlock", int'(dif.motor_open & dif.motor_close), 0);
    endtask

    task automatic set_in(input bit s, input bit ob, input bit lo, input bit lc, input bit lk, input bit fc);
        dif.sensor = s; dif.obstruct = ob; dif.lim_open = lo;
        dif.lim_closed = lc; dif.lock = lk; dif.fault_clr = fc;
    endtask

    // One step of the door rules as seen through the synchronised inputs
    task automatic model_step(input bit [5:0] syn);
        bit s, ob, lo, lc, lk, fc, rel;
        int nxt;
        bit hold_exp, trav_exp;
        {fc, lk, lc, lo, ob, s} = syn;
        hold_exp = (m_el + 1 == HT * P);
        trav_exp = (m_el + 1 == TT * P);
        nxt = m_st;
        rel = 1'b0;
        if (m_st != 4 && lo && lc) nxt = 4;
        else if (m_st == 0) nxt = (s && !lk) ? 1 : ((!lc && !s) ? 3 : 0);
        else if (m_st == 1) nxt = lo ? 2 : (trav_exp ? 4 : 1);
        else if (m_st == 2) begin
            if (s || ob) rel = 1'b1;
            else if (hold_exp) nxt = 3;
        end
        else if (m_st == 3) nxt = (s || ob) ? 1 : (lc ? 0 : (trav_exp ? 4 : 3));
        else if (m_st == 4) nxt = (fc && !(lo && lc)) ? (lc ? 0 : 3) : 4;
        else nxt = 4;
        m_el = (nxt != m_st || rel) ? 0 : m_el + 1;
        m_st = nxt;
    endtask

    task automatic model_edge();
        bit [5:0] syn;
        if (!rst_n) return;
        syn  = m_d2;
        m_d2 = m_d1;
        m_d1 = {dif.fault_clr, dif.lock, dif.lim_closed, dif.lim_open, dif.obstruct, dif.sensor};
        if (m_w < 2) m_w++;
        else if (dif.ena) model_step(syn);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset(input bit lc);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, lc, 1'b0, 1'b0);
        #1;
        m_st = 0; m_el = 0; m_w = 0; m_d1 = 6'd0; m_d2 = 6'd0;
        compare_all();
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int code, input int max);
        for (int i = 0; i < max; i++) begin
            if (int'(dif.state) == code) return;
            run(1);
        end
        check_val("wait_timeout", int'(dif.state), code);
    endtask

    // Counts post-edge samples that still show the given state, starting from one already seen
    task automatic dwell(input int code, input int max, output int n);
        n = 1;
        for (int i = 0; i < max; i++) begin
            run(1);
            if (int'(dif.state) == code) n++;
            else return;
        end
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        rst_n = 1'b0; dif.ena = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset idle, then reset-time homing
        do_reset(1'b1);
        run(20);
        check_val("idle_closed", int'(dif.state), 0);
        do_reset(1'b0);
        run(2);
        check_val("homing_e2", int'(dif.state), 0);
        run(1);
        check_val("homing_e3", int'(dif.state), 3);
        check_val("homing_mc", int'(dif.motor_close), 1);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(3);
        check_val("homed", int'(dif.state), 0);

        // full cycle with exact hold time
        dif.sensor = 1'b1; run(1); dif.sensor = 1'b0; run(2);
        check_val("open_e3", int'(dif.state), 1);
        check_val("open_mo", int'(dif.motor_open), 1);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        check_val("at_open", int'(dif.state), 2);
        dwell(2, 40, n);
        check_val("hold_len", n, HT * P);
        dif.lim_open = 1'b0;
        run(2);

        // reversal beats lim_closed in the same cycle
        dif.obstruct = 1'b1; dif.lim_closed = 1'b1;
        run(3);
        check_val("reversal", int'(dif.state), 1);
        check_val("reversal_mc", int'(dif.motor_close), 0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        dif.obstruct = 1'b1;
        run(30);
        check_val("obstruct_hold", int'(dif.state), 2);
        dif.obstruct = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && int'(dif.state) == 2; i++) begin run(1); n++; end
        check_val("release_len", n, 2 + HT * P);
        dif.lim_open = 1'b0;

        // travel timeout and fault clearing
        dif.sensor = 1'b1; run(1); dif.sensor = 1'b0;
        wait_state(1, 10);
        dwell(1, 40, n);
        check_val("travel_len", n, TT * P);
        check_val("timeout_fault", int'(dif.fault), 1);
        dif.fault_clr = 1'b1; run(3); dif.fault_clr = 1'b0;
        check_val("clr_to_closing", int'(dif.state), 3);
        run(25);
        check_val("closing_timeout", int'(dif.state), 4);
        dif.lim_closed = 1'b1; dif.fault_clr = 1'b1; run(3); dif.fault_clr = 1'b0;
        check_val("clr_to_closed", int'(dif.state), 0);

        // limit conflict, with fault_clr ignored while it lasts
        dif.lim_open = 1'b1; run(3);
        check_val("conflict", int'(dif.state), 4);
        dif.fault_clr = 1'b1; run(5);
        check_val("clr_ignored", int'(dif.state), 4);
        dif.lim_open = 1'b0; run(3); dif.fault_clr = 1'b0;
        check_val("conflict_cleared", int'(dif.state), 0);

        // lock, then a 10-cycle enable pause mid-opening
        dif.lock = 1'b1; dif.sensor = 1'b1; run(10);
        check_val("locked", int'(dif.state), 0);
        dif.lock = 1'b0; dif.sensor = 1'b0; run(3);
        dif.sensor = 1'b1; run(1); dif.sensor = 1'b0; dif.lim_closed = 1'b0;
        wait_state(1, 10);
        run(3);
        dif.ena = 1'b0; run(10);
        check_val("paused_state", int'(dif.state), 1);
        check_val("paused_mo", int'(dif.motor_open), 0);
        dif.ena = 1'b1;
        n = 14;
        for (int i = 0; i < 50; i++) begin
            run(1);
            if (int'(dif.state) == 1) n++;
            else break;
        end
        check_val("paused_travel_len", n, TT * P + 10);
        dif.lim_closed = 1'b1; dif.fault_clr = 1'b1; run(3); dif.fault_clr = 1'b0;

        // random field activity against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 6) dif.sensor = ~dif.sensor;
            if ($urandom_range(0, 99) < 3) dif.obstruct = ~dif.obstruct;
            if ($urandom_range(0, 99) < 3) dif.lim_open = ~dif.lim_open;
            if ($urandom_range(0, 99) < 3) dif.lim_closed = ~dif.lim_closed;
            if ($urandom_range(0, 99) < 2) dif.lock = ~dif.lock;
            if ($urandom_range(0, 99) < 4) dif.fault_clr = ~dif.fault_clr;
            if (dif.ena) dif.ena = ($urandom_range(0, 99) >= 2);
            else dif.ena = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 999) < 2) do_reset(1'($urandom_range(0, 1)));
            else run(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
